// File: rtl/dual_buffer_pkg.sv
// dual_buffer_pkg: shared types and constants for the multi-channel ping-pong capture buffer
package dual_buffer_pkg;
  typedef enum logic [2:0] {IDLE, ARMED, FILL, SWAP, HOLD} cap_state_t;
  typedef enum logic [1:0] {TRIG_FREE, TRIG_RISE, TRIG_FALL, TRIG_RSVD} trig_mode_t;
  localparam int ST_READY = 0;
  localparam int ST_LOCK = 1;
  localparam int ST_BANK = 2;
  localparam int ST_OVR = 3;
  localparam int CTRL_MODE = 0;
  localparam int CTRL_ARM = 2;
  localparam logic [15:0] STATE_ADDR_DEF = 16'h4000;
  localparam logic [15:0] CTRL_ADDR_DEF = 16'h4001;
  localparam logic [15:0] OVR_ADDR_DEF = 16'h4002;
endpackage

// File: rtl/dual_buffer_mc_ram.sv
// pingpong_ram: two-bank sample store for one channel with a registered read port
module pingpong_ram
  import dual_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  wr_bank,
  input  logic [AW-1:0]         wr_idx,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_bank,
  input  logic [AW-1:0]         rd_idx,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] mem [2*DEPTH];
  // capture write into the fill bank, synchronous read from the host bank
  always_ff @(posedge clk) begin
    if (we) mem[{wr_bank, wr_idx}] <= din;
    dout <= mem[{rd_bank, rd_idx}];
  end
endmodule

// File: rtl/dual_buffer_mc.sv
// dual_buffer_mc: multi-channel ping-pong ADC capture buffer with FSMC host access
module dual_buffer_mc
  import dual_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH = 1024,
  parameter int NUM_CH = 2,
  parameter int BUS_WIDTH = 16,
  parameter logic [BUS_WIDTH-1:0] STATE_ADDR = BUS_WIDTH'(STATE_ADDR_DEF),
  parameter logic [BUS_WIDTH-1:0] CTRL_ADDR = BUS_WIDTH'(CTRL_ADDR_DEF),
  parameter logic [BUS_WIDTH-1:0] OVR_ADDR = BUS_WIDTH'(OVR_ADDR_DEF)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         adc_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] sync_adc_data,
  input  logic                         stable,
  input  logic                         sync_signal_in,
  input  logic                         en,
  input  logic                         addr_en,
  input  logic                         rd_en,
  input  logic                         wr_en,
  input  logic [BUS_WIDTH-1:0]         rd_data,
  output logic [BUS_WIDTH-1:0]         wr_data,
  output logic                         has_switched
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam logic [BUS_WIDTH-1:0] SAMPLES = BUS_WIDTH'(NUM_CH*DEPTH);
  cap_state_t state;
  trig_mode_t act_mode;
  logic [1:0] mode;
  logic arm, lock, ready, sticky, wr_bank, sig_q, rd_en_q, load_d;
  logic [AW-1:0] wr_ptr;
  logic [15:0] ovr;
  logic [BUS_WIDTH-1:0] addr_q, addr_nxt, rd_val, state_word, ctrl_word;
  logic [DATA_WIDTH-1:0] ram_q [NUM_CH];
  logic [DATA_WIDTH-1:0] ram_sel;
  logic trig, wr_stb, cap_we, unused;
  assign unused = wr_en;
  assign addr_nxt = (en && addr_en) ? rd_data : addr_q;
  assign wr_stb = en && rd_en && !rd_en_q;
  assign cap_we = (state == FILL) && adc_valid;
  assign has_switched = ready;
  assign trig = act_mode == TRIG_FREE ? 1'b1 :
                act_mode == TRIG_FALL ? (sig_q & ~sync_signal_in) : (~sig_q & sync_signal_in);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pingpong_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_ram (
      .clk(clk),
      .we(cap_we),
      .wr_bank(wr_bank),
      .wr_idx(wr_ptr),
      .din(sync_adc_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .rd_bank(~wr_bank),
      .rd_idx(addr_nxt[AW-1:0]),
      .dout(ram_q[c])
    );
  end
  // host read mux: the RAM read is issued with the incoming address so the data is ready one clk later
  always_comb begin
    ram_sel = '0;
    for (int c = 0; c < NUM_CH; c++) if (addr_q[AW +: CW] == CW'(c)) ram_sel = ram_q[c];
    state_word = '0;
    state_word[ST_READY] = ready;
    state_word[ST_LOCK] = lock;
    state_word[ST_BANK] = wr_bank;
    state_word[ST_OVR] = sticky;
    ctrl_word = '0;
    ctrl_word[CTRL_MODE +: 2] = mode;
    ctrl_word[CTRL_ARM] = arm;
    rd_val = addr_q < SAMPLES ? BUS_WIDTH'(ram_sel) :
             addr_q == STATE_ADDR ? state_word :
             addr_q == CTRL_ADDR ? ctrl_word :
             addr_q == OVR_ADDR ? BUS_WIDTH'(ovr) : '0;
  end
  // address latch, host write-strobe edge detector and registered read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      load_d <= 1'b0;
      rd_en_q <= 1'b0;
      wr_data <= '0;
    end else begin
      addr_q <= addr_nxt;
      load_d <= en && addr_en;
      rd_en_q <= rd_en;
      if (load_d) wr_data <= rd_val;
    end
  end
  // capture FSM plus host-writable STATE/CTRL; host writes are applied last so they win a same-clk conflict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      act_mode <= TRIG_RISE;
      mode <= 2'd1;
      arm <= 1'b1;
      lock <= 1'b0;
      ready <= 1'b0;
      sticky <= 1'b0;
      wr_bank <= 1'b0;
      wr_ptr <= '0;
      ovr <= '0;
      sig_q <= 1'b0;
    end else begin
      sig_q <= sync_signal_in;
      case (state)
        IDLE: if (stable && arm) begin
          state <= ARMED;
          act_mode <= mode == 2'd3 ? TRIG_RISE : trig_mode_t'(mode);
        end
        ARMED: if (!stable) state <= IDLE;
          else if (trig) begin
            state <= FILL;
            wr_ptr <= '0;
          end
        FILL: if (adc_valid) begin
          wr_ptr <= wr_ptr + AW'(1);
          if (wr_ptr == AW'(DEPTH-1)) state <= SWAP;
        end
        SWAP: if (lock) state <= HOLD;
          else begin
            wr_bank <= ~wr_bank;
            ready <= 1'b1;
            sticky <= sticky | ready;
            state <= IDLE;
          end
        HOLD: begin
          if (adc_valid) begin
            ovr <= ovr + 16'(ovr != 16'hFFFF);
            sticky <= 1'b1;
          end
          if (!lock) state <= SWAP;
        end
        default: state <= IDLE;
      endcase
      if (wr_stb && addr_q == STATE_ADDR) begin
        lock <= rd_data[ST_LOCK - 1];
        if (rd_data[0] && !lock) ready <= 1'b0;
        if (!rd_data[0] && lock) sticky <= 1'b0;
      end
      if (wr_stb && addr_q == CTRL_ADDR) begin
        mode <= rd_data[CTRL_MODE +: 2];
        arm <= rd_data[CTRL_ARM];
      end
    end
  end
endmodule

// File: doc/dual_buffer_mc.md
Name: dual_buffer_mc

Overview:
Multi-channel ping-pong ADC capture buffer. It is the parametrised successor of the single-channel dual buffer. It captures NUM_CH channels of DEPTH samples each into a write bank, triggered by the comparator square wave. On completion it swaps banks so the MCU can read one bank over the FSMC slave bus while the other bank fills. New over the previous generation:
- single clock domain with an adc_valid strobe;
- selectable trigger mode;
- host read-lock with hold/overrun accounting;
- a status/control/overrun register set.

Parameters:
DATA_WIDTH, 12, ADC sample width per channel (≤ BUS_WIDTH)
DEPTH, 1024, samples per channel per bank (power of 2; NUM_CH*DEPTH ≤ 16'h4000)
NUM_CH, 2, channel count (power of 2, 1..8)
BUS_WIDTH, 16, FSMC data/address width
STATE_ADDR, 16'h4000, status/lock register
CTRL_ADDR, 16'h4001, control register
OVR_ADDR, 16'h4002, overrun counter (read-only)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
adc_valid  in  1  one-clk strobe: new sample set on sync_adc_data
sync_adc_data  in  NUM_CH*DATA_WIDTH  packed samples, ch0 in LSBs, already synchronised to clk
stable  in  1  ADC front end settled; capture permitted only while 1
sync_signal_in  in  1  comparator square wave, already synchronised to clk
en  in  1  FSMC chip select
addr_en  in  1  address phase strobe
rd_en  in  1  host-to-block write strobe (block reads rd_data)
wr_en  in  1  block-to-host read strobe
rd_data  in  BUS_WIDTH  address during address phase, write data during rd_en
wr_data  out  BUS_WIDTH  read data to host
has_switched  out  1  bank ready for host (mirrors STATE bit0)

Behaviour:
Reset (rst_n=0, async):
- wr_data=0, has_switched=0.
- write bank=0, lock=0, mode=1 (rising), overrun count=0, FSM=IDLE.
- RAM contents undefined.

Bus, address phase:
- With en=1, addr_en sampled high on a clk rise latches rd_data into addr_q.

Bus, read path:
- wr_data is registered.
- It updates exactly 1 clk after addr_q loads and holds until the next latch.
- wr_en is not used for gating; the host samples wr_data at least 2 clk after addr_en falls.
- Sample region, addr_q < NUM_CH*DEPTH: channel = addr_q / DEPTH, index = addr_q % DEPTH. Data is read from the read bank (= ~write bank), zero-extended.
- Out-of-map addresses read 0.

Bus, write path:
- A rising edge of rd_en while en=1 (1-clk registered detector) writes rd_data to the register at addr_q.
- Writes to the sample region or to OVR_ADDR are ignored.

STATE register:
- Read: bit0 ready, bit1 lock, bit2 write bank, bit3 overrun sticky, rest 0.
- Write: bit0 → lock.
- lock 0→1 clears ready and has_switched.
- lock 1→0 clears the overrun sticky bit.

CTRL register, read/write:
- bits[1:0] mode: 0 free-run, 1 rising edge, 2 falling edge, 3 reserved (treated as 1).
- bit2 arm_enable, reset value 1. Clearing it forces IDLE after the current fill completes.
- Mode changes take effect at the next ARMED entry.

OVR register:
- 16-bit count of sample sets dropped in HOLD.
- Saturates at 16'hFFFF; cleared only by reset.

Capture FSM:
- IDLE: → ARMED when stable=1 and arm_enable=1.
- ARMED: wait for the selected edge of sync_signal_in (prev-value detector); mode 0 proceeds immediately. → FILL and clear wr_ptr=0.
  - stable dropping in ARMED → IDLE.
  - An edge and adc_valid in the same clk: that sample is NOT captured; capture starts at the next adc_valid.
- FILL: each adc_valid writes all NUM_CH samples at wr_ptr into the write bank, then wr_ptr++.
  - After the sample at wr_ptr=DEPTH-1 → SWAP.
  - stable dropping mid-fill does not abort.
- SWAP (1 clk): if lock=0, toggle write bank, set ready/has_switched=1, → IDLE. If lock=1, → HOLD.
- HOLD: each adc_valid increments overrun and sets the sticky bit; samples are discarded. When lock falls → SWAP behaviour (toggle, ready=1) in the clk after lock is seen 0.
- Host read and FSM never touch the same bank, so simultaneous host read and capture write is legal.
- ready already set at a new swap: stays 1; the previous unread bank is lost, and the overrun sticky bit is set.

Decomposition:
- Package dual_buffer_pkg holds:
  - capture state enum (IDLE, ARMED, FILL, SWAP, HOLD);
  - trigger mode enum;
  - STATE/CTRL bit index constants;
  - default register address constants.
- Sub-module pingpong_ram: one per channel via generate. It contains 2×DEPTH×DATA_WIDTH, one write port (bank, idx) and one registered read port (bank, idx).

Test Plan:
1. Reset, then stable=1, mode 1, rising edge, then 1024 adc_valid with ch0=i, ch1=i+100 → has_switched=1 within 2 clk of the last sample; STATE reads 0x0005 (ready, write bank 1); addr 5 reads 5; addr 1024+5 reads 105.
2. Host writes STATE=1, then a second capture completes → FSM in HOLD, STATE bit1=1. 50 further adc_valid → OVR reads 50. Write STATE=0 → swap next clk, sticky bit cleared, STATE=0x0001.
3. CTRL=2 (falling), then rising edge only → no capture (wr_ptr stays 0). Falling edge → fill starts at the next adc_valid, not in the edge clk.
4. CTRL=0 (free-run), stable=1, no edges → back-to-back fills; bank toggles every 1024 samples (STATE bit2 alternates).
5. Assert rst_n=0 mid-FILL at sample 300 → wr_data=0, has_switched=0, STATE=0, CTRL reads 0x0005, OVR=0 immediately without a clk edge.
6. Read addr 0x3FFF and 0x4003 → wr_data=0. Write to sample addr 7 → buffer unchanged on readback.
